// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: unit indices, opcodes,
// FSM state encodings and instruction classes used by decoder and FSM.
package instr_sequencer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_UNIT_W     = 6;

    // Bus unit indices; 6 and 7 do not name a unit.
    localparam logic [2:0] U_MEM = 3'd0;
    localparam logic [2:0] U_AR  = 3'd1;
    localparam logic [2:0] U_DR0 = 3'd2;
    localparam logic [2:0] U_DR1 = 3'd3;
    localparam logic [2:0] U_ALU = 3'd4;
    localparam logic [2:0] U_PC  = 3'd5;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_SYS = 2'b11;

    localparam logic [7:0] HALT_CODE = 8'hC0;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_XFER,
        S_IMM,
        S_MEMRD,
        S_MEMWR,
        S_ALU,
        S_HALT
    } state_t;

    // What the execute phase of an instruction looks like.
    // C_NOP covers every instruction that goes straight back to fetch.
    typedef enum logic [2:0] {
        C_NOP,
        C_XFER,
        C_IMM,
        C_MEMRD,
        C_MEMWR,
        C_ALU,
        C_HALT
    } instr_class_t;

    function automatic logic unit_valid(input logic [2:0] idx);
        return idx <= U_PC;
    endfunction

endpackage

// File: rtl/instr_sequencer_decoder.sv
// Combinational instruction decoder: IR -> execute class, one-hot
// source/destination unit selects and a legal flag.
// Ports: i_ir (instruction register), o_class, o_src_onehot, o_dst_onehot,
//        o_legal (instruction has an execute phase).
module instr_sequencer_decoder
    import instr_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int UNIT_W     = DEFAULT_UNIT_W
) (
    input  logic [DATA_WIDTH-1:0] i_ir,
    output instr_class_t          o_class,
    output logic [UNIT_W-1:0]     o_src_onehot,
    output logic [UNIT_W-1:0]     o_dst_onehot,
    output logic                  o_legal
);

    logic [1:0] op;
    logic [2:0] src;
    logic [2:0] dst;
    logic       src_ok;
    logic       dst_ok;
    logic       dst_writable;

    assign op  = i_ir[7:6];
    assign src = i_ir[5:3];
    assign dst = i_ir[2:0];

    assign src_ok = unit_valid(src);
    assign dst_ok = unit_valid(dst);

    // LDI and ALU results cannot land in memory or the ALU itself.
    assign dst_writable = dst_ok && (dst != U_MEM) && (dst != U_ALU);

    assign o_src_onehot = src_ok ? (UNIT_W'(1) << src) : '0;
    assign o_dst_onehot = dst_ok ? (UNIT_W'(1) << dst) : '0;

    always_comb begin
        o_class = C_NOP;
        unique case (op)
            OP_MOV: begin
                // src == dst also removes MEM->MEM.
                if (src_ok && dst_ok && (src != dst)) begin
                    if (src == U_MEM) begin
                        o_class = C_MEMRD;
                    end else if (dst == U_MEM) begin
                        o_class = C_MEMWR;
                    end else begin
                        o_class = C_XFER;
                    end
                end
            end
            OP_LDI: begin
                if (dst_writable) begin
                    o_class = C_IMM;
                end
            end
            OP_ALU: begin
                if (dst_writable) begin
                    o_class = C_ALU;
                end
            end
            default: begin
                if (i_ir[7:0] == HALT_CODE) begin
                    o_class = C_HALT;
                end
            end
        endcase
    end

    assign o_legal = (o_class != C_NOP);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: fetches one instruction byte, latches it
// into IR and sequences the one-hot unit enables that move one value per
// instruction across the shared data bus.
// Ports: clk, rst_n (sync, active-low); i_data, i_mem_ready from memory;
//        o_mem_rd/o_mem_wr/o_mem_addr_source to memory; o_pc_counter_en;
//        o_unit_reg_input_en/o_unit_reg_output_en/o_unit_alu_output_en
//        (one-hot bus dest/src); o_alu_func, o_ir, o_halted.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int UNIT_W     = DEFAULT_UNIT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_mem_ready,
    output logic                  o_mem_rd,
    output logic                  o_mem_wr,
    output logic                  o_mem_addr_source,
    output logic                  o_pc_counter_en,
    output logic [UNIT_W-1:0]     o_unit_reg_input_en,
    output logic [UNIT_W-1:0]     o_unit_reg_output_en,
    output logic [UNIT_W-1:0]     o_unit_alu_output_en,
    output logic [2:0]            o_alu_func,
    output logic [DATA_WIDTH-1:0] o_ir,
    output logic                  o_halted
);

    localparam logic [UNIT_W-1:0] MEM_OH = UNIT_W'(1) << U_MEM;
    localparam logic [UNIT_W-1:0] ALU_OH = UNIT_W'(1) << U_ALU;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] ir_d;

    instr_class_t      dec_class;
    logic [UNIT_W-1:0] src_oh;
    logic [UNIT_W-1:0] dst_oh;
    logic              dec_legal;

    logic              mem_rd_c;
    logic              mem_wr_c;
    logic              addr_src_c;
    logic              pc_en_c;
    logic [UNIT_W-1:0] in_en_c;
    logic [UNIT_W-1:0] out_en_c;
    logic [UNIT_W-1:0] alu_en_c;
    logic              halted_c;

    instr_sequencer_decoder #(
        .DATA_WIDTH (DATA_WIDTH),
        .UNIT_W     (UNIT_W)
    ) u_decoder (
        .i_ir         (ir_q),
        .o_class      (dec_class),
        .o_src_onehot (src_oh),
        .o_dst_onehot (dst_oh),
        .o_legal      (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        addr_src_c = 1'b0;
        pc_en_c    = 1'b0;
        in_en_c    = '0;
        out_en_c   = '0;
        alu_en_c   = '0;
        halted_c   = 1'b0;

        unique case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_rd_c   = 1'b1;
                addr_src_c = 1'b1;
                if (i_mem_ready) begin
                    ir_d    = i_data;
                    pc_en_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                if (dec_legal) begin
                    unique case (dec_class)
                        C_XFER:  state_d = S_XFER;
                        C_IMM:   state_d = S_IMM;
                        C_MEMRD: state_d = S_MEMRD;
                        C_MEMWR: state_d = S_MEMWR;
                        C_ALU:   state_d = S_ALU;
                        C_HALT:  state_d = S_HALT;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_XFER: begin
                out_en_c = src_oh;
                in_en_c  = dst_oh;
                state_d  = S_FETCH;
            end
            S_IMM: begin
                mem_rd_c   = 1'b1;
                addr_src_c = 1'b1;
                out_en_c   = MEM_OH;
                if (i_mem_ready) begin
                    in_en_c = dst_oh;
                    // Loading PC overrides the increment; never do both.
                    pc_en_c = !dst_oh[U_PC];
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                mem_rd_c = 1'b1;
                out_en_c = MEM_OH;
                if (i_mem_ready) begin
                    in_en_c = dst_oh;
                    state_d = S_FETCH;
                end
            end
            S_MEMWR: begin
                mem_wr_c = 1'b1;
                out_en_c = src_oh;
                if (i_mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_ALU: begin
                out_en_c = ALU_OH;
                alu_en_c = ALU_OH;
                in_en_c  = dst_oh;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    // Reset is synchronous, but outputs must go quiet in the very cycle
    // rst_n is low so an in-flight instruction cannot write or count.
    assign o_mem_rd             = rst_n & mem_rd_c;
    assign o_mem_wr             = rst_n & mem_wr_c;
    assign o_mem_addr_source    = rst_n & addr_src_c;
    assign o_pc_counter_en      = rst_n & pc_en_c;
    assign o_unit_reg_input_en  = rst_n ? in_en_c : '0;
    assign o_unit_reg_output_en = rst_n ? out_en_c : '0;
    assign o_unit_alu_output_en = rst_n ? alu_en_c : '0;
    assign o_alu_func           = rst_n ? ir_q[5:3] : 3'b000;
    assign o_ir                 = rst_n ? ir_q : '0;
    assign o_halted             = rst_n & halted_c;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Fetch/decode/execute controller for the data register controller and program counter. It fetches one instruction byte per instruction over a memory read handshake, latches it into an internal IR, and sequences the one-hot unit enables (reg input/output, ALU output, PC count, memory address source) that move one value per instruction across the shared data bus. It sits between the memory interface and the data register controller/ALU in bb_core.

Parameters:
DATA_WIDTH, 8, width of data bus and instruction register
UNIT_W, 6, width of one-hot unit enable vectors

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_data  in  DATA_WIDTH  shared data bus (instruction/immediate source during fetch)
i_mem_ready  in  1  memory done this cycle (read data valid on i_data / write accepted)
o_mem_rd  out  1  memory read request, held until i_mem_ready
o_mem_wr  out  1  memory write request, held until i_mem_ready
o_mem_addr_source  out  1  1 = address from PC, 0 = address from AR
o_pc_counter_en  out  1  PC increment strobe
o_unit_reg_input_en  out  UNIT_W  one-hot bus destination
o_unit_reg_output_en  out  UNIT_W  one-hot bus source
o_unit_alu_output_en  out  UNIT_W  bit4 = ALU drives bus; other bits 0
o_alu_func  out  3  ALU function, equals IR[5:3]
o_ir  out  DATA_WIDTH  current instruction register
o_halted  out  1  sequencer in HALT

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. All outputs are 0 while in reset and in S_RST. IR = 0. Reset mid-instruction aborts it immediately, with no PC increment and no register write.
- Unit index: 0 MEM, 1 AR, 2 DR0, 3 DR1, 4 ALU, 5 PC. Indices 6 and 7 are invalid.
- Instruction = {op[7:6], src[5:3], dst[2:0]}.
  - 00 MOV src->dst.
  - 01 LDI dst: next byte is the immediate.
  - 10 ALU: func = src field, result goes to dst.
  - 11 with 0xC0 = HALT; other 11 codes are NOP.
- States: S_RST -> S_FETCH -> S_DECODE -> {S_XFER | S_IMM | S_MEMRD | S_MEMWR | S_ALU | S_HALT | S_FETCH}.
- S_RST: 1 cycle after rst_n goes high, then S_FETCH.
- S_FETCH: o_mem_rd=1, o_mem_addr_source=1. On i_mem_ready: IR <= i_data, o_pc_counter_en=1 for that cycle only, go to S_DECODE. Without ready, stay in S_FETCH and hold the request.
- S_DECODE: 1 cycle, no enables asserted.
  - NOP, invalid index, MOV src==dst, MOV MEM->MEM, or any ALU/LDI dst of MEM or ALU -> S_FETCH.
  - MOV src=MEM -> S_MEMRD. MOV dst=MEM -> S_MEMWR. MOV reg->reg -> S_XFER.
  - LDI -> S_IMM. ALU -> S_ALU. 0xC0 -> S_HALT.
- S_XFER: 1 cycle, output_en[src]=1 and input_en[dst]=1.
- S_IMM: o_mem_rd=1, addr_source=1, output_en[0]=1. On ready: input_en[dst]=1 and pc_counter_en=1.
- S_MEMRD: o_mem_rd=1, addr_source=0, output_en[0]=1. On ready: input_en[dst]=1.
- S_MEMWR: o_mem_wr=1, addr_source=0, output_en[src]=1, all held until ready.
- S_ALU: 1 cycle, output_en[4]=1, alu_output_en[4]=1, input_en[dst]=1.
- Every execute state returns to S_FETCH after it completes.
- Jump: MOV dst=PC writes input_en[5]. pc_counter_en is never asserted in the same cycle as input_en[5].
- S_HALT: absorbing, o_halted=1, all enables 0. Only reset exits it.
- Strobes qualified by i_mem_ready are combinational from state and i_mem_ready. At most one bit is set in each one-hot vector. o_mem_rd and o_mem_wr are never asserted together.
- Minimum latency: reg->reg and ALU instructions take 3 cycles (fetch ready in its first cycle); LDI and memory instructions take 3 cycles plus memory wait cycles.

Decomposition:
- Shared package/include (define.v): DATA_WIDTH, unit indices (U_MEM..U_PC), op codes, HALT code 0xC0, state encodings.
- One sub-module is natural: instr_decoder. It is combinational: IR -> {class, src_onehot, dst_onehot, legal}. The FSM stays in instr_sequencer.

Test Plan:
- Reset then program {0x42, 0x5A}, ready=1 always -> S_FETCH pulses pc_counter_en; S_IMM gives output_en=6'b000001, input_en=6'b000100, pc_counter_en=1; PC advanced by 2.
- IR 0x13 (MOV DR0->DR1) -> one S_XFER cycle, output_en=6'b000100, input_en=6'b001000; fetch to next fetch is 3 cycles.
- IR 0x99 (ALU func 3 -> AR) -> o_alu_func=3, alu_output_en=6'b010000, input_en=6'b000010 for 1 cycle.
- IR 0x10 (MOV DR0->MEM) with i_mem_ready low 3 cycles -> o_mem_wr held 4 cycles, addr_source=0, output_en=6'b000100 stable, no pc_counter_en.
- IR 0x1D (MOV DR1->PC) -> input_en=6'b100000 with pc_counter_en=0; IR 0x00, 0x36 (src 6) and 0x00 (MEM->MEM) -> straight back to S_FETCH with no enables.
- IR 0xC0 -> o_halted=1, no further o_mem_rd; rst_n low 1 cycle during S_MEMRD wait -> all outputs 0, IR=0, S_RST then fetch.
